axi_read_responder: RTL and testbench
=====================================

# axi_read_responder

AXI read-channel responder (slave end of AR/R) that models the DDR side behind the prefetcher. It accepts read requests on AR, queues them in order, waits a programmable latency per request, and returns `len+1` data beats on R with the request's ID and `last` on the final beat. Beat data is a deterministic function of the beat address, so a bench can check every returned block without a memory model. It is used as the memory-side endpoint in prefetcher and system-level benches.

## Interface
- `ADDR_BITS`, 32, address width
- `TID_WIDTH`, 4, transaction ID width
- `BURST_LEN_WIDTH`, 8, AR len width; a burst has len+1 beats
- `LOG_BLOCK_DATA_BYTES`, 6, log2 bytes per beat; `BLOCK_DATA_SIZE_BITS` = 8<<LOG_BLOCK_DATA_BYTES, and must be a multiple of ADDR_BITS
- `LOG_REQ_DEPTH`, 2, log2 request-queue entries
- `LAT_BITS`, 8, latency counter width
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `s_ar_valid`  in  1  request valid
- `s_ar_ready`  out  1  request accepted when valid&ready
- `s_ar_len`  in  BURST_LEN_WIDTH  beats-1
- `s_ar_addr`  in  ADDR_BITS  first beat address
- `s_ar_id`  in  TID_WIDTH  request ID
- `s_r_valid`  out  1  beat valid
- `s_r_ready`  in  1  beat consumed when valid&ready
- `s_r_last`  out  1  final beat of burst
- `s_r_data`  out  BLOCK_DATA_SIZE_BITS  beat data
- `s_r_id`  out  TID_WIDTH  ID of the burst being returned
- `cfg_latency`  in  LAT_BITS  wait cycles inserted before each burst
- `reqCnt`  out  LOG_REQ_DEPTH+1  occupied queue entries
- `busy`  out  1  state != IDLE or reqCnt != 0

## Operation
- Request queue: FIFO of {addr, len, id}, depth 2^LOG_REQ_DEPTH. Push on AR handshake. `s_ar_ready` = ~full, using pre-pop occupancy, so a pop in the same cycle gives no bypass. Forced to 0 while `reset` is high.
- FSM states:
  - IDLE: when the queue is non-empty, pop the head into working regs {addr, len, id}, clear beat index, and sample `cfg_latency`=L. Go to BURST if L==0, else go to WAIT with cnt=L-1.
  - WAIT: if cnt==0 go to BURST, else cnt--.
  - BURST: `s_r_valid`=1. On each handshake, beat index++. When the handshake occurs with `s_r_last`=1, go to IDLE.
- `s_r_last` = (beat index == len) in BURST.
- `s_r_data` = beat address replicated BLOCK_DATA_SIZE_BITS/ADDR_BITS times.
- Beat address = addr + beat index × 2^LOG_BLOCK_DATA_BYTES, computed mod 2^ADDR_BITS (wraps, no error).
- Outside BURST, `s_r_data`, `s_r_id` and `s_r_last` are 0.
- `cfg_latency` is used only at pop. Changes during WAIT or BURST do not affect the current burst.
- Responses return strictly in request order, regardless of ID.
- The queue may accept new requests during WAIT and BURST.

## Timing
- Reset values: `s_ar_ready`=0 during reset, then 1 (queue empty); `s_r_valid`=0, `s_r_last`=0, `s_r_data`=0, `s_r_id`=0, `reqCnt`=0, `busy`=0; FSM in IDLE.
- Reset mid-burst: the burst is abandoned and the queue is cleared. Outputs hold reset values from the cycle after `reset` is sampled high.
- Latency: AR handshake in cycle 0 on an idle responder gives the first `s_r_valid` in cycle 2+L. Each beat takes one cycle when `s_r_ready`=1.
- Back-to-back bursts: after the last beat's handshake, the next burst's first beat appears at least 2+L cycles later (IDLE pop cycle plus WAIT).
- R handshake rule: once `s_r_valid` is high it stays high, and data/id/last stay stable, until `s_r_ready`.
- `reqCnt` updates the cycle after a push or pop. Simultaneous push and pop leave it unchanged.
- len = 2^BURST_LEN_WIDTH-1 is legal (256 beats); the beat index is BURST_LEN_WIDTH bits wide.

## Test plan
- Single burst: L=2, AR addr 0x1000, len 3, id 5 at cycle 0, `s_r_ready`=1 -> `s_r_valid` in cycles 4–7 with data words 0x1000, 0x1040, 0x1080, 0x10C0 (×16 each); `s_r_last` only in cycle 7; id 5 throughout; `busy`=0 from cycle 8.
- Backpressure: same request with `s_r_ready` alternating 0/1 starting at 0 -> each beat held stable for 2 cycles; 4 beats over 8 cycles; no beat is skipped or duplicated.
- Queue full: L=0, `s_r_ready`=0, `s_ar_valid` held high with distinct ids 1–6 -> 5 handshakes accepted (cycles 0–4), `s_ar_ready`=0 from cycle 5, `reqCnt`=4. Releasing `s_r_ready` returns the bursts in id order 1–5, and the 6th request is accepted after the first pop following burst 1.
- Address wrap: addr 0xFFFFFFC0, len 1 -> beats carry 0xFFFFFFC0 then 0x00000000; last on the second beat.
- Latency zero and maximum: L=0 gives first valid at cycle 2; L=255 gives first valid at cycle 257; changing `cfg_latency` mid-WAIT has no effect.
- Reset mid-burst: assert `reset` on beat 2 of a 4-beat burst with 2 queued requests -> next cycle `s_r_valid`=0, `reqCnt`=0, FSM in IDLE; no further beats after `reset` deasserts.

Source files
------------

// File: rtl/axi_read_responder_if.sv
// AR/R read-channel bundle between a read master and the responder.
interface axi_read_responder_if #(
  parameter int ADDR_BITS            = 32,
  parameter int TID_WIDTH            = 4,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6
) ();
  localparam int BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES;

  logic                            s_ar_valid;
  logic                            s_ar_ready;
  logic [BURST_LEN_WIDTH-1:0]      s_ar_len;
  logic [ADDR_BITS-1:0]            s_ar_addr;
  logic [TID_WIDTH-1:0]            s_ar_id;
  logic                            s_r_valid;
  logic                            s_r_ready;
  logic                            s_r_last;
  logic [BLOCK_DATA_SIZE_BITS-1:0] s_r_data;
  logic [TID_WIDTH-1:0]            s_r_id;

  modport master (
    output s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
    input  s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );

  modport slave (
    input  s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
    output s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );
endinterface

// File: rtl/axi_read_responder.sv
// Memory-side AR/R responder: queues read requests in order, waits a
// programmable latency per request, then returns len+1 beats whose data is
// the beat address replicated across the data bus.
module axi_read_responder #(
  parameter int ADDR_BITS            = 32,
  parameter int TID_WIDTH            = 4,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_REQ_DEPTH        = 2,
  parameter int LAT_BITS             = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  axi_read_responder_if.slave      bus,
  input  logic [LAT_BITS-1:0]      cfg_latency,
  output logic [LOG_REQ_DEPTH:0]   reqCnt,
  output logic                     busy
);
  localparam int DEPTH                = 1 << LOG_REQ_DEPTH;
  localparam int BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int REPL                 = BLOCK_DATA_SIZE_BITS / ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] BEAT_STRIDE = ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  // Request queue storage (data only, never reset)
  logic [ADDR_BITS-1:0]       q_addr_mem [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] q_len_mem  [DEPTH];
  logic [TID_WIDTH-1:0]       q_id_mem   [DEPTH];

  logic [LOG_REQ_DEPTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_REQ_DEPTH:0]     count_q, count_d;
  state_t                     state_q, state_d;
  logic [LAT_BITS-1:0]        lat_cnt_q, lat_cnt_d;
  logic [BURST_LEN_WIDTH-1:0] beat_idx_q, beat_idx_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [ADDR_BITS-1:0]       beat_addr_q, beat_addr_d;

  logic full, push, pop, r_hs, in_burst, last_beat;

  assign full      = (count_q == (LOG_REQ_DEPTH+1)'(DEPTH));
  assign push      = bus.s_ar_valid & bus.s_ar_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign in_burst  = (state_q == BURST);
  assign last_beat = in_burst && (beat_idx_q == len_q);
  assign r_hs      = in_burst && bus.s_r_ready;

  assign bus.s_ar_ready = ~full & ~reset;
  assign bus.s_r_valid  = in_burst;
  assign bus.s_r_last   = last_beat;
  assign bus.s_r_id     = in_burst ? id_q : '0;
  assign bus.s_r_data   = in_burst ? {REPL{beat_addr_q}} : '0;
  assign reqCnt         = count_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);

  // Next-state logic for the queue pointers, occupancy and burst FSM
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    beat_idx_d  = beat_idx_q;
    len_d       = len_q;
    id_d        = id_q;
    beat_addr_d = beat_addr_q;

    if (push) wr_ptr_d = wr_ptr_q + LOG_REQ_DEPTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LOG_REQ_DEPTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (LOG_REQ_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOG_REQ_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          beat_addr_d = q_addr_mem[rd_ptr_q];
          len_d       = q_len_mem[rd_ptr_q];
          id_d        = q_id_mem[rd_ptr_q];
          beat_idx_d  = '0;
          if (cfg_latency == '0) begin
            state_d = BURST;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = cfg_latency - LAT_BITS'(1);
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) state_d = BURST;
        else                 lat_cnt_d = lat_cnt_q - LAT_BITS'(1);
      end
      BURST: begin
        if (r_hs) begin
          beat_idx_d  = beat_idx_q + BURST_LEN_WIDTH'(1);
          beat_addr_d = beat_addr_q + BEAT_STRIDE;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      beat_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  // Burst working registers and queue storage; outputs are gated by state
  always_ff @(posedge clk) begin
    len_q       <= len_d;
    id_q        <= id_d;
    beat_addr_q <= beat_addr_d;
    if (push) begin
      q_addr_mem[wr_ptr_q] <= bus.s_ar_addr;
      q_len_mem[wr_ptr_q]  <= bus.s_ar_len;
      q_id_mem[wr_ptr_q]   <= bus.s_ar_id;
    end
  end
endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: single burst, backpressure, full
// queue ordering, address wrap, latency extremes and reset mid-burst.
module tb_axi_read_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_latency;
  logic [2:0] reqCnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  axi_read_responder_if #(.ADDR_BITS(32), .TID_WIDTH(4), .BURST_LEN_WIDTH(8),
                          .LOG_BLOCK_DATA_BYTES(6)) bus ();

  axi_read_responder #(
    .ADDR_BITS(32), .TID_WIDTH(4), .BURST_LEN_WIDTH(8),
    .LOG_BLOCK_DATA_BYTES(6), .LOG_REQ_DEPTH(2), .LAT_BITS(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cfg_latency (cfg_latency),
    .reqCnt      (reqCnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] beat(input logic [31:0] a);
    return {16{a}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic v, input logic [31:0] a, input logic [7:0] l,
                          input logic [3:0] id);
    bus.s_ar_valid = v;
    bus.s_ar_addr  = a;
    bus.s_ar_len   = l;
    bus.s_ar_id    = id;
  endtask

  logic [3:0] got_ids[$];
  int         next_id;
  logic       exp_v;

  initial begin
    reset = 1'b1;
    cfg_latency = 8'd0;
    bus.s_r_ready = 1'b0;
    drive_ar(1'b0, 32'h0, 8'h0, 4'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_arready_in_reset", bus.s_ar_ready, 1'b0);
    check("rst_rvalid", bus.s_r_valid, 1'b0);
    check("rst_reqcnt", reqCnt, 3'd0);
    check("rst_busy", busy, 1'b0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_arready_after", bus.s_ar_ready, 1'b1);
    check("rst_rdata", bus.s_r_data, '0);
    check("rst_rid_last", {bus.s_r_id, bus.s_r_last}, 5'd0);
    cyc();

    // Single burst, L=2: beats in cycles 4..7
    cfg_latency = 8'd2;
    bus.s_r_ready = 1'b1;
    drive_ar(1'b1, 32'h1000, 8'd3, 4'd5);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) drive_ar(1'b0, 32'h0, 8'h0, 4'h0);
      @(negedge clk);
      if (c == 0) check("t1_arready", bus.s_ar_ready, 1'b1);
      if (c == 1) check("t1_reqcnt", reqCnt, 3'd1);
      exp_v = (c >= 4) && (c <= 7);
      check($sformatf("t1_valid@%0d", c), bus.s_r_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t1_data@%0d", c), bus.s_r_data, beat(32'h1000 + 32'((c - 4) * 64)));
        check($sformatf("t1_last@%0d", c), bus.s_r_last, c == 7);
        check($sformatf("t1_id@%0d", c), bus.s_r_id, 4'd5);
      end else begin
        check($sformatf("t1_data0@%0d", c), bus.s_r_data, '0);
      end
      if (c == 4) check("t1_busy_on", busy, 1'b1);
      if (c == 8) check("t1_busy_off", busy, 1'b0);
      cyc();
    end

    // Backpressure: ready high on odd cycles, each beat held two cycles
    drive_ar(1'b1, 32'h1000, 8'd3, 4'd5);
    for (int c = 0; c < 14; c++) begin
      bus.s_r_ready = (c % 2) == 1;
      if (c == 1) drive_ar(1'b0, 32'h0, 8'h0, 4'h0);
      @(negedge clk);
      exp_v = (c >= 4) && (c <= 11);
      check($sformatf("t2_valid@%0d", c), bus.s_r_valid, exp_v);
      if (exp_v) begin
        check($sformatf("t2_data@%0d", c), bus.s_r_data, beat(32'h1000 + 32'(((c - 4) / 2) * 64)));
        check($sformatf("t2_last@%0d", c), bus.s_r_last, c >= 10);
      end
      cyc();
    end

    // Queue full with L=0 and R stalled, then drain in order
    cfg_latency = 8'd0;
    bus.s_r_ready = 1'b0;
    next_id = 1;
    got_ids.delete();
    for (int c = 0; c < 40; c++) begin
      drive_ar(next_id <= 6, 32'h2000 + 32'(next_id * 256), 8'd0, 4'(next_id));
      bus.s_r_ready = (c >= 7);
      @(negedge clk);
      if (c <= 4) check($sformatf("t3_arready@%0d", c), bus.s_ar_ready, 1'b1);
      if (c == 5 || c == 6 || c == 8) check($sformatf("t3_arready_full@%0d", c), bus.s_ar_ready, 1'b0);
      if (c == 9) check("t3_arready_reopen", bus.s_ar_ready, 1'b1);
      if (c == 5) check("t3_reqcnt_full", reqCnt, 3'd4);
      if (c == 1) check("t3_valid_c1", bus.s_r_valid, 1'b0);
      if (c == 2) check("t3_valid_L0", bus.s_r_valid, 1'b1);
      if (bus.s_ar_valid && bus.s_ar_ready) next_id++;
      if (bus.s_r_valid && bus.s_r_ready) begin
        got_ids.push_back(bus.s_r_id);
        check($sformatf("t3_last@%0d", c), bus.s_r_last, 1'b1);
        check($sformatf("t3_data@%0d", c), bus.s_r_data, beat(32'h2000 + 32'(bus.s_r_id) * 32'd256));
      end
      cyc();
    end
    check("t3_accepted", 32'(next_id), 32'd7);
    check("t3_nbursts", 32'(got_ids.size()), 32'd6);
    for (int i = 0; i < got_ids.size() && i < 6; i++)
      check($sformatf("t3_order%0d", i), got_ids[i], 4'(i + 1));
    check("t3_busy_end", busy, 1'b0);

    // Address wrap, L=1: beats in cycles 3 and 4
    cfg_latency = 8'd1;
    bus.s_r_ready = 1'b1;
    drive_ar(1'b1, 32'hFFFF_FFC0, 8'd1, 4'd3);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) drive_ar(1'b0, 32'h0, 8'h0, 4'h0);
      @(negedge clk);
      check($sformatf("t4_valid@%0d", c), bus.s_r_valid, (c == 3) || (c == 4));
      if (c == 3) check("t4_data0", {bus.s_r_last, bus.s_r_data}, {1'b0, beat(32'hFFFF_FFC0)});
      if (c == 4) check("t4_data1", {bus.s_r_last, bus.s_r_data}, {1'b1, beat(32'h0000_0000)});
      cyc();
    end

    // Maximum latency with cfg_latency changed mid-WAIT
    cfg_latency = 8'd255;
    drive_ar(1'b1, 32'h3000, 8'd0, 4'd2);
    for (int c = 0; c < 260; c++) begin
      if (c == 1) drive_ar(1'b0, 32'h0, 8'h0, 4'h0);
      if (c == 2) cfg_latency = 8'd0;
      @(negedge clk);
      if (c == 2 || c == 128 || c == 256 || c == 258)
        check($sformatf("t5_valid_low@%0d", c), bus.s_r_valid, 1'b0);
      if (c == 257) begin
        check("t5_valid_257", bus.s_r_valid, 1'b1);
        check("t5_data_257", bus.s_r_data, beat(32'h3000));
        check("t5_id_257", bus.s_r_id, 4'd2);
      end
      cyc();
    end

    // Reset on the second beat with two requests queued
    cfg_latency = 8'd0;
    bus.s_r_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c <= 2) drive_ar(1'b1, 32'h4000 + 32'(c * 32'h1000), 8'd3, 4'(7 + c));
      else        drive_ar(1'b0, 32'h0, 8'h0, 4'h0);
      reset = (c == 3);
      @(negedge clk);
      if (c == 2) check("t6_first_beat", bus.s_r_data, beat(32'h4000));
      if (c == 3) begin
        check("t6_second_beat", bus.s_r_data, beat(32'h4040));
        check("t6_reqcnt_before", reqCnt, 3'd2);
        check("t6_arready_in_reset", bus.s_ar_ready, 1'b0);
      end
      if (c == 4) begin
        check("t6_reqcnt_after", reqCnt, 3'd0);
        check("t6_busy_after", busy, 1'b0);
        check("t6_data_after", bus.s_r_data, '0);
      end
      if (c >= 4) check($sformatf("t6_valid@%0d", c), bus.s_r_valid, 1'b0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
